program_sequencer: RTL

//   Fetches instructions from a synchronous program ROM and feeds them to the
//   9-bit processor datapath over DIN/run. Completes each handshake on Done.

---
 rtl/program_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/program_sequencer.sv
// Purpose : fetches words from a synchronous program ROM and issues them to the 9-bit datapath via DIN/run.
// Latency : start -> run in 3 cycles (5 for mvi); Done -> next run in 3 cycles.
// Backpress: one instruction in flight; the next fetch waits for Done, and Done missing for TIMEOUT cycles -> ERROR.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   start, halt_req       launch program from address 0 / stop at next instruction boundary
//   rom_addr, rom_data    ROM address (always equals pc) and its word, one cycle later
//   DIN, run              word presented to the datapath and one-cycle begin pulse
//   IRin, Done            datapath loaded its IR / finished the instruction
//   pc                    address of the next word to fetch
//   busy, halted, err     status: running / stopped cleanly / stopped on fault
//   instr_cnt             instructions completed since start, saturating at 255
module program_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int PROG_LEN = 32,
    parameter int TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [8:0]        rom_data,
    output logic [8:0]        DIN,
    output logic              run,
    input  logic              IRin,
    input  logic              Done,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [7:0]        instr_cnt
);

    localparam int                TW        = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);
    // EXEC lasts at most TIMEOUT-1 cycles so err rises exactly TIMEOUT cycles after run.
    localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT - 2);
    localparam logic [2:0]        OP_MVI    = 3'b001;
    localparam logic [2:0]        OP_HALT   = 3'b111;

    typedef enum logic [3:0] {
        IDLE, FETCH_I, LATCH_I, FETCH_M, LATCH_M, ISSUE, EXEC, HALTED, ERROR
    } state_t;

    state_t        state;
    logic [8:0]    imm;
    logic [TW-1:0] timer;
    logic          halt_flag;
    logic          end_flag;   // last program word has been consumed
    logic          is_mvi;     // instruction in flight carries an immediate

    // The ROM registers its address internally, so presenting pc directly
    // lets the LATCH_* state see the word fetched in the FETCH_* state.
    assign rom_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            DIN       <= '0;
            imm       <= '0;
            instr_cnt <= '0;
            timer     <= '0;
            halt_flag <= 1'b0;
            end_flag  <= 1'b0;
            is_mvi    <= 1'b0;
            run       <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else begin
            run <= 1'b0;
            if (busy && halt_req)
                halt_flag <= 1'b1;

            case (state)
                IDLE, HALTED, ERROR: begin
                    if (start) begin
                        state     <= FETCH_I;
                        pc        <= '0;
                        instr_cnt <= '0;
                        halt_flag <= 1'b0;
                        end_flag  <= 1'b0;
                        busy      <= 1'b1;
                        halted    <= 1'b0;
                        err       <= 1'b0;
                    end
                end

                FETCH_I: begin
                    if (halt_flag) begin
                        state  <= HALTED;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state <= LATCH_I;
                    end
                end

                LATCH_I: begin
                    DIN    <= rom_data;
                    pc     <= pc + 1'b1;
                    is_mvi <= (rom_data[8:6] == OP_MVI);
                    if (pc == LAST_ADDR)
                        end_flag <= 1'b1;
                    if (rom_data[8:6] == OP_HALT) begin
                        state  <= HALTED;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (rom_data[8:6] == OP_MVI) begin
                        if (pc == LAST_ADDR) begin
                            // immediate word would lie past the program end
                            state <= ERROR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            state <= FETCH_M;
                        end
                    end else begin
                        state <= ISSUE;
                        run   <= 1'b1;
                    end
                end

                FETCH_M: state <= LATCH_M;

                LATCH_M: begin
                    imm   <= rom_data;
                    pc    <= pc + 1'b1;
                    if (pc == LAST_ADDR)
                        end_flag <= 1'b1;
                    state <= ISSUE;
                    run   <= 1'b1;
                end

                ISSUE: begin
                    timer <= '0;
                    state <= EXEC;
                end

                EXEC: begin
                    timer <= timer + 1'b1;
                    if (IRin && is_mvi)
                        DIN <= imm;
                    if (Done) begin
                        if (instr_cnt != 8'hFF)
                            instr_cnt <= instr_cnt + 8'd1;
                        if (end_flag) begin
                            state  <= HALTED;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state <= FETCH_I;
                        end
                    end else if (timer == TMO_LAST) begin
                        state <= ERROR;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
